// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the serial add/subtract unit: FSM state
// encodings and the elaboration-time parameter sanity check.
package serial_addsub_pkg;

  typedef logic [1:0] stateT;

  localparam stateT ST_IDLE = 2'd0;
  localparam stateT ST_RUN  = 2'd1;
  localparam stateT ST_DONE = 2'd2;

  // True when the operand width can be split into whole digits.
  function automatic bit digitFits(input int width, input int digit);
    return (digit > 0) && (width >= 2) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// Request/result bundle for serial_addsub. The master side issues
// operations and the slave side (the adder) reports status and results.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, cin, a, b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, cin, a, b,
    output busy, done, sum, cout, ovf
  );

endinterface

// File: rtl/serial_addsub_digit.sv
// Combinational DIGIT-bit ripple-carry slice. Besides the sum and the
// carry out it exposes the carry into its top bit, which the parent
// needs for signed overflow detection.
module addsub_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  input  logic             i_cin,
  output logic [DIGIT-1:0] o_s,
  output logic             o_cout,
  output logic             o_cMsbIn
);

  logic [DIGIT:0] w_carry;

  // Ripple the carry through one full adder per bit, LSB first.
  always_comb begin
    w_carry    = '0;
    o_s        = '0;
    w_carry[0] = i_cin;
    for (int i = 0; i < DIGIT; i++) begin
      o_s[i]       = i_a[i] ^ i_b[i] ^ w_carry[i];
      w_carry[i+1] = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
    end
  end

  assign o_cout   = w_carry[DIGIT];
  assign o_cMsbIn = w_carry[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor. One DIGIT-bit slice is reused for
// WIDTH/DIGIT cycles with the carry held in a register between digits.
// Subtraction is a + ~b + ~cin, i.e. a - b - cin, so cout is NOT-borrow.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic           clk,
  input  logic           rst,
  serial_addsub_if.slave bus
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  generate
    if (!digitFits(WIDTH, DIGIT)) begin : g_paramCheck
      $error("serial_addsub: WIDTH must be >= 2 and an exact multiple of DIGIT");
    end
  endgenerate

  stateT            r_state;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_shA;
  logic [WIDTH-1:0] r_shB;
  logic             r_carry;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [DIGIT-1:0] w_s;
  logic             w_c;
  logic             w_cMsb;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_resultNext;

  addsub_digit #(
    .DIGIT (DIGIT)
  ) u_digit (
    .i_a      (r_shA[DIGIT-1:0]),
    .i_b      (r_shB[DIGIT-1:0]),
    .i_cin    (r_carry),
    .o_s      (w_s),
    .o_cout   (w_c),
    .o_cMsbIn (w_cMsb)
  );

  assign w_accept = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last   = (r_state == ST_RUN) && (r_count == CW'(NDIG - 1));

  // New digit enters the result register from the MSB side.
  always_comb begin
    w_resultNext                    = r_result >> DIGIT;
    w_resultNext[WIDTH-1 -: DIGIT]  = w_s;
  end

  // Sequencer: IDLE waits for start, RUN walks the digits, DONE lasts one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_count <= '0;
          r_state <= w_accept ? ST_RUN : ST_IDLE;
        end
        ST_RUN: begin
          if (w_last) begin
            r_state <= ST_DONE;
            r_count <= '0;
          end else begin
            r_count <= r_count + CW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_count <= '0;
        end
      endcase
    end
  end

  // Operand shifters and running carry: loaded on an accepted start, advanced each RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shA    <= '0;
      r_shB    <= '0;
      r_carry  <= 1'b0;
      r_result <= '0;
    end else if (w_accept) begin
      r_shA    <= bus.a;
      r_shB    <= bus.sub ? ~bus.b : bus.b;
      r_carry  <= bus.sub ? ~bus.cin : bus.cin;
      r_result <= '0;
    end else if (r_state == ST_RUN) begin
      r_shA    <= r_shA >> DIGIT;
      r_shB    <= r_shB >> DIGIT;
      r_carry  <= w_c;
      r_result <= w_resultNext;
    end
  end

  // Visible results change only on the edge that enters DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_last) begin
      r_sum  <= w_resultNext;
      r_cout <= w_c;
      r_ovf  <= w_c ^ w_cMsb;
    end
  end

  assign bus.busy = (r_state == ST_RUN);
  assign bus.done = (r_state == ST_DONE);
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub. Two instances run side by side
// (DIGIT=1 and DIGIT=4, both 8 bits wide) and are exercised one after the
// other with directed and random operations. Expected results come from an
// integer-arithmetic reference model; timing is checked cycle by cycle.
module tb_serial_addsub;

  typedef struct packed {
    logic       sub;
    logic       cin;
    logic [7:0] a;
    logic [7:0] b;
  } opT;

  logic clk;
  logic rst1;
  logic rst4;

  int checkCount;
  int errorCount;

  logic [7:0] prevSum  [2];
  logic       prevCout [2];
  logic       prevOvf  [2];

  serial_addsub_if #(.WIDTH(8)) bus1 ();
  serial_addsub_if #(.WIDTH(8)) bus4 ();

  serial_addsub #(.WIDTH(8), .DIGIT(1)) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1)
  );

  serial_addsub #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clk (clk),
    .rst (rst4),
    .bus (bus4)
  );

  // Free-running 10-unit clock; rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count every comparison and report mismatches with both values.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Number of RUN cycles for instance d (0 -> DIGIT=1, 1 -> DIGIT=4).
  function automatic int ndigOf(input int d);
    return (d == 0) ? 8 : 2;
  endfunction

  // Reference: plain integer arithmetic on the operands, no bit-level carries.
  task automatic refModel(input opT op, output logic [7:0] s, output logic c, output logic v);
    int ua, ub, sa, sb, ci, r, rs;
    ua = int'(op.a);
    ub = int'(op.b);
    sa = int'($signed(op.a));
    sb = int'($signed(op.b));
    ci = op.cin ? 1 : 0;
    if (!op.sub) begin
      r  = ua + ub + ci;
      rs = sa + sb + ci;
      c  = (r > 255);
    end else begin
      r  = ua - ub - ci;
      rs = sa - sb - ci;
      c  = (r >= 0);
    end
    s = r[7:0];
    v = (rs > 127) || (rs < -128);
  endtask

  function automatic opT randomOp();
    opT op;
    op.sub = 1'($urandom_range(0, 1));
    op.cin = 1'($urandom_range(0, 1));
    op.a   = 8'($urandom);
    op.b   = 8'($urandom);
    return op;
  endfunction

  // Present an operation and raise start for instance d.
  task automatic applyStimulus(input int d, input opT op);
    if (d == 0) begin
      bus1.sub = op.sub; bus1.cin = op.cin; bus1.a = op.a; bus1.b = op.b; bus1.start = 1'b1;
    end else begin
      bus4.sub = op.sub; bus4.cin = op.cin; bus4.a = op.a; bus4.b = op.b; bus4.start = 1'b1;
    end
  endtask

  task automatic releaseStart(input int d);
    if (d == 0) bus1.start = 1'b0;
    else        bus4.start = 1'b0;
  endtask

  task automatic setReset(input int d, input logic v);
    if (d == 0) rst1 = v;
    else        rst4 = v;
  endtask

  task automatic sample(input int d, output logic bsy, output logic dn,
                        output logic [7:0] sm, output logic co, output logic ov);
    if (d == 0) begin
      bsy = bus1.busy; dn = bus1.done; sm = bus1.sum; co = bus1.cout; ov = bus1.ovf;
    end else begin
      bsy = bus4.busy; dn = bus4.done; sm = bus4.sum; co = bus4.cout; ov = bus4.ovf;
    end
  endtask

  // Walk one operation whose start is already driven. Checks busy/done on
  // every cycle, that old results hold during RUN, and the final result.
  // injectAt>0 pulses a stray start in that RUN cycle; chain issues nextOp
  // during the DONE cycle.
  task automatic runOp(input int d, input opT op, input int injectAt, input bit chain, input opT nextOp);
    int nd;
    logic [7:0] es, sm;
    logic ec, ev, bsy, dn, co, ov;
    nd = ndigOf(d);
    refModel(op, es, ec, ev);
    for (int k = 1; k <= nd + 1; k++) begin
      @(negedge clk);
      sample(d, bsy, dn, sm, co, ov);
      if (k == 1) releaseStart(d);
      checkOutput($sformatf("busy d%0d k%0d", d, k), 32'(bsy), 32'(k <= nd));
      checkOutput($sformatf("done d%0d k%0d", d, k), 32'(dn), 32'(k == nd + 1));
      if (k == 1) begin
        checkOutput($sformatf("sumHeld d%0d", d), 32'(sm), 32'(prevSum[d]));
        checkOutput($sformatf("coutHeld d%0d", d), 32'(co), 32'(prevCout[d]));
        checkOutput($sformatf("ovfHeld d%0d", d), 32'(ov), 32'(prevOvf[d]));
      end
      if (k == nd + 1) begin
        checkOutput($sformatf("sum d%0d a=%h b=%h sub=%0b cin=%0b", d, op.a, op.b, op.sub, op.cin), 32'(sm), 32'(es));
        checkOutput($sformatf("cout d%0d a=%h b=%h sub=%0b cin=%0b", d, op.a, op.b, op.sub, op.cin), 32'(co), 32'(ec));
        checkOutput($sformatf("ovf d%0d a=%h b=%h sub=%0b cin=%0b", d, op.a, op.b, op.sub, op.cin), 32'(ov), 32'(ev));
        prevSum[d]  = es;
        prevCout[d] = ec;
        prevOvf[d]  = ev;
      end
      if (injectAt > 0 && k == injectAt) applyStimulus(d, randomOp());
      if (injectAt > 0 && k == injectAt + 1) releaseStart(d);
      if (chain && k == nd + 1) applyStimulus(d, nextOp);
    end
  endtask

  // Quiet cycles: no busy, no done, results held.
  task automatic idleCheck(input int d, input int n);
    logic [7:0] sm;
    logic bsy, dn, co, ov;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      sample(d, bsy, dn, sm, co, ov);
      checkOutput($sformatf("idleBusy d%0d", d), 32'(bsy), 32'd0);
      checkOutput($sformatf("idleDone d%0d", d), 32'(dn), 32'd0);
      checkOutput($sformatf("idleSum d%0d", d), 32'(sm), 32'(prevSum[d]));
    end
  endtask

  // Abort an operation with an asynchronous reset mid-RUN.
  task automatic resetMidRun(input int d, input opT op, input int atCycle);
    logic [7:0] sm;
    logic bsy, dn, co, ov;
    applyStimulus(d, op);
    for (int k = 1; k <= atCycle; k++) begin
      @(negedge clk);
      sample(d, bsy, dn, sm, co, ov);
      if (k == 1) releaseStart(d);
      checkOutput($sformatf("preRstBusy d%0d k%0d", d, k), 32'(bsy), 32'd1);
    end
    #2 setReset(d, 1'b1);
    #1 sample(d, bsy, dn, sm, co, ov);
    checkOutput($sformatf("rstBusy d%0d", d), 32'(bsy), 32'd0);
    checkOutput($sformatf("rstDone d%0d", d), 32'(dn), 32'd0);
    checkOutput($sformatf("rstSum d%0d", d), 32'(sm), 32'd0);
    checkOutput($sformatf("rstCout d%0d", d), 32'(co), 32'd0);
    checkOutput($sformatf("rstOvf d%0d", d), 32'(ov), 32'd0);
    prevSum[d]  = 8'h00;
    prevCout[d] = 1'b0;
    prevOvf[d]  = 1'b0;
    @(negedge clk);
    setReset(d, 1'b0);
    idleCheck(d, ndigOf(d) + 2);
  endtask

  // Main sequence: reset, directed cases for both instances, then random traffic.
  initial begin
    opT op, op2, none;
    logic [7:0] sm;
    logic bsy, dn, co, ov;
    int nd, inj;
    bit chain;

    checkCount = 0;
    errorCount = 0;
    none = '0;
    rst1 = 1'b1;
    rst4 = 1'b1;
    bus1.start = 1'b0; bus1.sub = 1'b0; bus1.cin = 1'b0; bus1.a = '0; bus1.b = '0;
    bus4.start = 1'b0; bus4.sub = 1'b0; bus4.cin = 1'b0; bus4.a = '0; bus4.b = '0;
    for (int d = 0; d < 2; d++) begin
      prevSum[d] = 8'h00; prevCout[d] = 1'b0; prevOvf[d] = 1'b0;
    end

    @(posedge clk);
    #2;
    for (int d = 0; d < 2; d++) begin
      sample(d, bsy, dn, sm, co, ov);
      checkOutput($sformatf("resetBusy d%0d", d), 32'(bsy), 32'd0);
      checkOutput($sformatf("resetDone d%0d", d), 32'(dn), 32'd0);
      checkOutput($sformatf("resetSum d%0d", d), 32'(sm), 32'd0);
      checkOutput($sformatf("resetCout d%0d", d), 32'(co), 32'd0);
      checkOutput($sformatf("resetOvf d%0d", d), 32'(ov), 32'd0);
    end
    @(negedge clk);
    rst1 = 1'b0;
    rst4 = 1'b0;

    for (int d = 0; d < 2; d++) begin
      nd = ndigOf(d);
      $display("[TB] directed cases on instance %0d (%0d run cycles)", d, nd);

      op = '{sub: 1'b0, cin: 1'b0, a: 8'h5A, b: 8'h3C};
      applyStimulus(d, op); runOp(d, op, 0, 1'b0, none); idleCheck(d, 2);

      op = '{sub: 1'b1, cin: 1'b0, a: 8'h10, b: 8'h20};
      applyStimulus(d, op); runOp(d, op, 0, 1'b0, none); idleCheck(d, 1);

      op = '{sub: 1'b1, cin: 1'b0, a: 8'h80, b: 8'h01};
      applyStimulus(d, op); runOp(d, op, 0, 1'b0, none); idleCheck(d, 1);

      op = '{sub: 1'b0, cin: 1'b0, a: 8'hFF, b: 8'h01};
      applyStimulus(d, op); runOp(d, op, 0, 1'b0, none); idleCheck(d, 1);

      op  = '{sub: 1'b0, cin: 1'b1, a: 8'hFF, b: 8'h01};
      op2 = '{sub: 1'b1, cin: 1'b1, a: 8'h00, b: 8'h00};
      applyStimulus(d, op); runOp(d, op, 0, 1'b1, op2); runOp(d, op2, 0, 1'b0, none);
      idleCheck(d, 1);

      op = '{sub: 1'b0, cin: 1'b0, a: 8'h7F, b: 8'h01};
      applyStimulus(d, op); runOp(d, op, (d == 0) ? 4 : 2, 1'b0, none); idleCheck(d, nd + 2);

      op = '{sub: 1'b0, cin: 1'b1, a: 8'hC3, b: 8'h5E};
      resetMidRun(d, op, (d == 0) ? 5 : 1);

      op = '{sub: 1'b1, cin: 1'b1, a: 8'h33, b: 8'h44};
      applyStimulus(d, op); runOp(d, op, 0, 1'b0, none); idleCheck(d, 1);

      $display("[TB] random traffic on instance %0d", d);
      for (int i = 0; i < 30; i++) begin
        op    = randomOp();
        op2   = randomOp();
        chain = ($urandom_range(0, 3) == 0);
        inj   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, nd)) : 0;
        applyStimulus(d, op);
        runOp(d, op, inj, chain, op2);
        if (chain) runOp(d, op2, 0, 1'b0, none);
        idleCheck(d, 1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised, sequential successor to the team's 3-bit ripple parallel adder.
- Adds or subtracts two WIDTH-bit operands using one DIGIT-bit full-adder slice, processing DIGIT bits per clock with a registered carry.
- Uses a start/busy/done handshake.
- Used wherever area matters more than latency, e.g. datapaths that share one adder.

Parameters:
- WIDTH, 8: operand and result width in bits; must be ≥ 2.
- DIGIT, 1: bits processed per cycle; must divide WIDTH exactly, otherwise elaboration fails.
- NDIG, WIDTH/DIGIT (derived, not overridable): number of RUN cycles.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE or DONE.
- sub  in  1  0 = add, 1 = subtract; latched at start.
- cin  in  1  carry-in (add) or borrow-in (sub); latched at start.
- a  in  WIDTH  operand A; latched at start.
- b  in  WIDTH  operand B; latched at start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when the result becomes valid.
- sum  out  WIDTH  result; held stable until the next accepted start.
- cout  out  1  carry out (add), or NOT-borrow (sub).
- ovf  out  1  two's-complement signed overflow.

Behaviour:
- Reset: asynchronous, active-high; fixed. While rst is high:
  - state = IDLE
  - busy = 0, done = 0, sum = 0, cout = 0, ovf = 0
  - digit counter, operand shift registers and carry register all cleared.
  - Reset mid-RUN aborts the operation; no done pulse is produced.
- FSM states: IDLE, RUN, DONE.
  - IDLE, start=1: latch operands, go to RUN. start=0: stay.
  - RUN: one digit per cycle, LSB digit first. Counter runs 0..NDIG-1; at NDIG-1 go to DONE.
  - DONE: done=1 for exactly this cycle. start=1: latch and go to RUN (back-to-back). Otherwise go to IDLE.
- start while in RUN is ignored; the in-flight operation is not disturbed.
- Operand prep at start:
  - shift-A register = a
  - shift-B register = sub ? ~b : b
  - carry = sub ? ~cin : cin, so sub computes a − b − cin.
- Each RUN cycle:
  - {c, s} = A[DIGIT-1:0] + B[DIGIT-1:0] + carry
  - s shifts into the result register from the MSB side.
  - A and B shift right by DIGIT bits.
  - carry = c.
- On the final digit:
  - cout = final carry.
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1. With DIGIT > 1, the carry into the MSB is taken from the slice's internal bit-level carry.
  - sum, cout and ovf update together, on the edge that enters DONE. Before that edge, sum, cout and ovf keep their previous values; the result register is internal until then.
- Timing: start sampled at edge 0 → busy high for cycles 1..NDIG → done high in cycle NDIG+1. Total latency is NDIG+1 clocks.
- Outputs hold after DONE through IDLE until the edge that ends the next operation.
- Subtract: cout = 1 means no borrow.
- Width rule: all arithmetic is modulo 2^WIDTH; there is no saturation.

Decomposition:
- Shared package (serial_addsub_pkg, or a header with localparams):
  - state encodings ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2
  - the check that WIDTH is divisible by DIGIT
- One sub-module: addsub_digit.
  - Purely combinational DIGIT-bit ripple of 1-bit full adders.
  - Outputs: s[DIGIT-1:0], cout, and the carry into its MSB (c_msb_in).
  - The top level contains the FSM, counter, shift registers and flag logic.

Test Plan:
1. WIDTH=8, DIGIT=1: a=8'h5A, b=8'h3C, sub=0, cin=0, start at edge 0 → busy in cycles 1–8; done in cycle 9 with sum=8'h96, cout=0, ovf=1.
2. Subtract, a=8'h10, b=8'h20, cin=0 → sum=8'hF0, cout=0 (borrow), ovf=0. Then a=8'h80, b=8'h01 → sum=8'h7F, cout=1, ovf=1.
3. Add a=8'hFF, b=8'h01, cin=1 → sum=8'h01, cout=1, ovf=0. Issue the next start during the DONE cycle → accepted, busy the next cycle, second result correct.
4. Pulse start with new operands in cycle 4 of RUN → ignored; first result unchanged; no second done.
5. Assert rst asynchronously in cycle 5 of RUN → busy, done, sum, cout, ovf = 0 immediately; no done pulse follows; a fresh start after reset works normally.
6. WIDTH=8, DIGIT=4: a=8'hFF, b=8'h01, add → busy in cycles 1–2; done in cycle 3 with sum=8'h00, cout=1, ovf=0.
